// File: rtl/multi_dataflow_engine_fsm_pkg.sv
// Shared types for the multi-dataflow compute path.
//
// Contents:
//   CNT_WIDTH_DEFAULT       default width of the job output counters
//   ctrl_kernel_adapter_t   control driven towards the kernel adapter (start)
//   flags_kernel_adapter_t  status returned by the kernel adapter (done/ready/idle)
//   engine_state_t          sequencing states of the engine FSM
package multi_dataflow_package;

  localparam int unsigned CNT_WIDTH_DEFAULT = 16;

  typedef struct packed {
    logic start;
  } ctrl_kernel_adapter_t;

  typedef struct packed {
    logic done;
    logic ready;
    logic idle;
  } flags_kernel_adapter_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } engine_state_t;

endpackage

// File: rtl/multi_dataflow_engine_fsm_if.sv
// Kernel-adapter link between the engine FSM and the kernel adapter.
//
// Signals:
//   ctrl_ka   engine -> adapter control (start)
//   flags_ka  adapter -> engine status (done, ready, idle)
// Modports:
//   master    engine side (drives ctrl_ka, reads flags_ka)
//   slave     adapter side (reads ctrl_ka, drives flags_ka)
interface multi_dataflow_engine_fsm_if;
  import multi_dataflow_package::*;

  ctrl_kernel_adapter_t  ctrl_ka;
  flags_kernel_adapter_t flags_ka;

  modport master (output ctrl_ka, input flags_ka);
  modport slave  (input ctrl_ka, output flags_ka);

endinterface

// File: rtl/multi_dataflow_engine_fsm_watchdog.sv
// Saturating stall watchdog for the engine COMPUTE phase.
//
// The count is the number of cycles elapsed since the last kick (or since
// the counter was enabled). expired_o flags the cycle whose end would bring
// the count to TIMEOUT_CYCLES-1 without a kick, so the owner can leave on
// that same edge. A kick in that cycle wins.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    synchronous clear of the count
//   en_i       counting enable; the count is held at 0 while low
//   kick_i     activity seen this cycle; restarts the elapsed-cycle count
//   expired_o  timeout reached this cycle (combinational)
module multi_dataflow_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  input  logic kick_i,
  output logic expired_o
);

  localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_WIDTH-1:0] WD_MAX  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] WD_TRIP = TO_WIDTH'(TIMEOUT_CYCLES - 2);

  logic [TO_WIDTH-1:0] wd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (clear_i || !en_i) begin
      wd_q <= '0;
    end else if (kick_i) begin
      // The cycle after a kick is the first elapsed cycle.
      wd_q <= TO_WIDTH'(1);
    end else if (wd_q != WD_MAX) begin
      wd_q <= wd_q + TO_WIDTH'(1);
    end
  end

  assign expired_o = en_i & ~kick_i & (wd_q >= WD_TRIP);

endmodule

// File: rtl/multi_dataflow_engine_fsm.sv
// Compute-sequencing engine sitting directly upstream of the kernel adapter.
//
// A job request issues a single kernel start, then counts per-element done
// pulses from the adapter up to the latched output count and finishes with
// a one-cycle done pulse. A stalled kernel trips the watchdog and parks the
// engine in ERROR until a soft clear. All outputs are registered.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   test_mode_i  test mode (no functional effect)
//   clear_i      synchronous soft clear, highest priority after reset
//   start_i      job request, sampled only in IDLE
//   n_outputs_i  outputs expected for the job, latched on an accepted start
//   ka           kernel-adapter link (master): ctrl_ka.start out, flags_ka in
//   busy_o       high in every state except IDLE
//   done_o       one-cycle job-complete pulse
//   err_o        high in ERROR
//   cnt_out_o    done pulses counted in the current job
//   state_o      current FSM state, for debug
module multi_dataflow_engine_fsm
  import multi_dataflow_package::*;
#(
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         test_mode_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [CNT_WIDTH-1:0]         n_outputs_i,
  multi_dataflow_engine_fsm_if.master  ka,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [CNT_WIDTH-1:0]         cnt_out_o,
  output engine_state_t                state_o
);

  engine_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 zero_job;
  logic                 wd_expired;
  ctrl_kernel_adapter_t ctrl_q;
  logic                 busy_q, done_q, err_q;

  // ready/idle do not steer sequencing; a kernel going idle early is caught
  // by the watchdog instead.
  logic unused_inputs;
  assign unused_inputs = ^{test_mode_i, ka.flags_ka.ready, ka.flags_ka.idle};

  multi_dataflow_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .en_i      (state_q == ST_COMPUTE),
    .kick_i    (ka.flags_ka.done),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    zero_job = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (n_outputs_i != '0) begin
            n_d     = n_outputs_i;
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            // Empty job: acknowledge without touching the kernel.
            zero_job = 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // A done pulse takes precedence over a simultaneous timeout.
        if (ka.flags_ka.done) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == n_q - CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_i) begin
      state_d  = ST_IDLE;
      n_d      = '0;
      cnt_d    = '0;
      zero_job = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      ctrl_q.start <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      ctrl_q.start <= (state_d == ST_START);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE) || zero_job;
      err_q        <= (state_d == ST_ERROR);
    end
  end

  assign ka.ctrl_ka = ctrl_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cnt_out_o  = cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multi_dataflow_engine_fsm.sv
// Directed testbench for multi_dataflow_engine_fsm.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so every check sees the registered values of the cycle just entered.
module tb_multi_dataflow_engine_fsm;
  import multi_dataflow_package::*;

  localparam int unsigned CW = 16;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          test_mode = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] n_out = '0;
  logic          busy, done, err;
  logic [CW-1:0] cnt;
  engine_state_t st;

  multi_dataflow_engine_fsm_if ka_if ();

  multi_dataflow_engine_fsm #(
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .clear_i     (clear),
    .start_i     (start),
    .n_outputs_i (n_out),
    .ka          (ka_if),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .cnt_out_o   (cnt),
    .state_o     (st)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int start_cnt = 0;
  int s0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ka_if.ctrl_ka.start === 1'b1) start_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic kdone();
    ka_if.flags_ka.done = 1'b1;
    tick();
    ka_if.flags_ka.done = 1'b0;
  endtask

  initial begin
    ka_if.flags_ka = '0;

    // Reset
    #2 rst_n = 1'b0;
    #10;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_state", 32'(st), 32'(ST_IDLE));
    check("rst_kstart", 32'(ka_if.ctrl_ka.start), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Basic job, n=4, dones at t0+5/7/9/11
    s0 = start_cnt;
    n_out = 16'd4; start = 1'b1;
    tick();                                     // t0+1
    start = 1'b0;
    check("bas_kstart", 32'(ka_if.ctrl_ka.start), 32'd1);
    check("bas_state_start", 32'(st), 32'(ST_START));
    check("bas_busy", 32'(busy), 32'd1);
    tick();                                     // t0+2
    check("bas_kstart_low", 32'(ka_if.ctrl_ka.start), 32'd0);
    check("bas_state_comp", 32'(st), 32'(ST_COMPUTE));
    ticks(3);                                   // t0+5
    kdone();                                    // t0+6
    check("bas_cnt1", 32'(cnt), 32'd1);
    tick();
    kdone();                                    // t0+8
    check("bas_cnt2", 32'(cnt), 32'd2);
    tick();
    kdone();                                    // t0+10
    check("bas_cnt3", 32'(cnt), 32'd3);
    check("bas_no_early_done", 32'(done), 32'd0);
    tick();                                     // t0+11
    ka_if.flags_ka.done = 1'b1;
    tick();                                     // t0+12, extra done held into DONE
    check("bas_done", 32'(done), 32'd1);
    check("bas_cnt4", 32'(cnt), 32'd4);
    check("bas_state_done", 32'(st), 32'(ST_DONE));
    tick();                                     // t0+13, extra done in IDLE too
    ka_if.flags_ka.done = 1'b0;
    check("bas_done_1cyc", 32'(done), 32'd0);
    check("bas_busy_low", 32'(busy), 32'd0);
    check("bas_cnt_hold", 32'(cnt), 32'd4);
    tick();
    check("bas_cnt_hold2", 32'(cnt), 32'd4);
    check("bas_one_kstart", 32'(start_cnt - s0), 32'd1);

    // Zero-length job
    s0 = start_cnt;
    n_out = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_state", 32'(st), 32'(ST_IDLE));
    tick();
    check("zero_done_1cyc", 32'(done), 32'd0);
    check("zero_no_kstart", 32'(start_cnt - s0), 32'd0);

    // Done in the last cycle before timeout keeps the job alive, n=3
    n_out = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    kdone();                                    // done at c0, now c1
    ticks(13);                                  // c14
    ka_if.flags_ka.done = 1'b1;
    tick();                                     // c15
    ka_if.flags_ka.done = 1'b0;
    check("edge_no_err", 32'(err), 32'd0);
    check("edge_cnt2", 32'(cnt), 32'd2);
    check("edge_state", 32'(st), 32'(ST_COMPUTE));
    ticks(12);                                  // c0'+13
    kdone();
    check("edge_done", 32'(done), 32'd1);
    check("edge_cnt3", 32'(cnt), 32'd3);
    tick();

    // Timeout, n=2, one done then silence
    n_out = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    kdone();                                    // done at c0, now c1
    check("to_cnt1", 32'(cnt), 32'd1);
    ticks(13);                                  // c14
    check("to_err_early", 32'(err), 32'd0);
    tick();                                     // c15
    check("to_err", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    check("to_state", 32'(st), 32'(ST_ERROR));
    s0 = start_cnt;
    n_out = 16'd5; start = 1'b1;
    tick();
    check("err_start_ign", 32'(st), 32'(ST_ERROR));
    check("err_cnt_hold", 32'(cnt), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clr_state", 32'(st), 32'(ST_IDLE));
    check("clr_err", 32'(err), 32'd0);
    check("clr_cnt", 32'(cnt), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("err_no_kstart", 32'(start_cnt - s0), 32'd0);

    // Clear and start together in IDLE: clear wins
    n_out = 16'd3; start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check("clrstart_state", 32'(st), 32'(ST_IDLE));
    check("clrstart_busy", 32'(busy), 32'd0);

    // Async reset mid-COMPUTE, n=8 at cnt=3
    n_out = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    kdone(); kdone(); kdone();
    check("ar_cnt3", 32'(cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_cnt", 32'(cnt), 32'd0);
    check("ar_state", 32'(st), 32'(ST_IDLE));
    check("ar_kstart", 32'(ka_if.ctrl_ka.start), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    n_out = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_job_kstart", 32'(ka_if.ctrl_ka.start), 32'd1);
    tick();
    kdone();
    check("ar_job_done", 32'(done), 32'd1);
    check("ar_job_cnt", 32'(cnt), 32'd1);
    tick();

    // Back-to-back: start during DONE is dropped, re-assert in IDLE
    n_out = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    kdone(); kdone();
    check("b2b_done", 32'(done), 32'd1);
    n_out = 16'd7; start = 1'b1;
    tick();
    check("b2b_ign_state", 32'(st), 32'(ST_IDLE));
    check("b2b_ign_kstart", 32'(ka_if.ctrl_ka.start), 32'd0);
    check("b2b_ign_busy", 32'(busy), 32'd0);
    n_out = 16'd1;
    tick();
    start = 1'b0;
    check("b2b_state_start", 32'(st), 32'(ST_START));
    check("b2b_cnt_restart", 32'(cnt), 32'd0);
    tick();
    kdone();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_cnt1", 32'(cnt), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
